// File: rtl/ssd_pkg.sv
// Shared types, segment patterns and helpers for the multiplexed seven-segment driver.
// Segment patterns are active-low, bit 0 = segment a .. bit 6 = segment g.
package ssd_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic {
        CONV_IDLE,
        CONV_SHIFT
    } conv_state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [31:0] pow10(input int unsigned n);
        logic [31:0] r;
        r = 32'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
module bin_bcd_seq
    import ssd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_t          state, state_nx;
    logic [BIN_W-1:0]     sr;
    logic [4*DIGITS-1:0]  work;
    logic [4*DIGITS-1:0]  adj;
    logic [CNT_W-1:0]     cnt;

    // The first shift happens on the start edge (nothing to adjust in an all-zero
    // BCD field), so the last shift lands one edge early and done can be decoded
    // from registers, letting the caller latch the result on the BIN_W-th edge.
    assign done = (state == CONV_SHIFT) && (cnt == CNT_W'(BIN_W));
    assign busy = (state == CONV_SHIFT);
    assign bcd  = work;

    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = work[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            CONV_IDLE:  if (start) state_nx = CONV_SHIFT;
            CONV_SHIFT: if (done)  state_nx = CONV_IDLE;
            default:    state_nx = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CONV_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr   <= '0;
            work <= '0;
            cnt  <= '0;
        end else if (state == CONV_IDLE && start) begin
            work <= (4*DIGITS)'(bin[BIN_W-1]);
            sr   <= bin << 1;
            cnt  <= CNT_W'(1);
        end else if (state == CONV_SHIFT && !done) begin
            {work, sr} <= {adj, sr} << 1;
            cnt        <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// N-digit multiplexed seven-segment driver: load/busy handshake, sequential BCD
// conversion, leading-zero blanking, decimal points and overflow dashes.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int BIN_W    = 8,
    parameter int PRESCALE = 256,
    parameter int BLANK_LZ = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [BIN_W-1:0]  bin_in,
    input  logic [DIGITS-1:0] dp_in,
    output logic              busy,
    output logic              overflow,
    output logic [DIGITS-1:0] sel,
    output logic [7:0]        dig
);

    localparam int          IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int          PRE_W = $clog2(PRESCALE);
    localparam logic [31:0] LIMIT = pow10(DIGITS) - 32'd1;

    logic                 start;
    logic                 conv_done;
    logic [4*DIGITS-1:0]  conv_bcd;
    logic [4*DIGITS-1:0]  bcd_disp;
    logic [DIGITS-1:0]    dp_pend;
    logic [DIGITS-1:0]    dp_lat;
    logic                 ovf_pend;
    logic [PRE_W-1:0]     presc;
    logic [IDX_W-1:0]     idx;
    logic [DIGITS-1:0]    blank_mask;
    logic [3:0]           cur_nib;
    logic                 cur_blank;
    logic                 cur_dp;
    logic [6:0]           cur_seg;

    assign start = load & ~busy;

    bin_bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin_in),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_pend  <= '0;
            ovf_pend <= 1'b0;
        end else if (start) begin
            dp_pend  <= dp_in;
            ovf_pend <= (32'(bin_in) > LIMIT);
        end
    end

    // Display, dp and overflow switch together so the old value shows until done.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_disp <= '0;
            dp_lat   <= '0;
            overflow <= 1'b0;
        end else if (conv_done) begin
            bcd_disp <= conv_bcd;
            dp_lat   <= dp_pend;
            overflow <= ovf_pend;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRE_W'(PRESCALE - 1)) begin
            presc <= '0;
            idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        logic all_zero;
        blank_mask = '0;
        all_zero   = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            all_zero = all_zero && (bcd_disp[4*(DIGITS-1-k) +: 4] == 4'd0);
            blank_mask[DIGITS-1-k] = all_zero;
        end
        blank_mask[0] = 1'b0;
        if (BLANK_LZ == 0) begin
            blank_mask = '0;
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = bcd_disp[4*i +: 4];
                cur_blank = blank_mask[i];
                cur_dp    = dp_lat[i];
            end
        end
        if (overflow) begin
            cur_seg = SEG_DASH;
        end else if (cur_blank) begin
            cur_seg = SEG_BLANK;
        end else begin
            cur_seg = bcd_to_seg(cur_nib);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel <= '1;
            dig <= 8'hFF;
        end else begin
            sel <= ~(DIGITS'(1) << idx);
            dig <= {~cur_dp, cur_seg};
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench: two drivers (8-bit and 16-bit input) against a value-level reference model.
module tb_ssd_scan_driver;

    localparam int D = 4;
    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld0 = 1'b0, ld1 = 1'b0;
    logic [7:0]  bin0 = '0;
    logic [15:0] bin1 = '0;
    logic [3:0]  dp0 = '0, dp1 = '0;
    logic        busy0, busy1, ovf0, ovf1;
    logic [3:0]  sel0, sel1;
    logic [7:0]  dig0, dig1;

    always #5 clk = ~clk;

    ssd_scan_driver #(.DIGITS(D), .BIN_W(8), .PRESCALE(P), .BLANK_LZ(1)) dut0 (
        .clk(clk), .reset(reset), .load(ld0), .bin_in(bin0), .dp_in(dp0),
        .busy(busy0), .overflow(ovf0), .sel(sel0), .dig(dig0)
    );

    ssd_scan_driver #(.DIGITS(D), .BIN_W(16), .PRESCALE(P), .BLANK_LZ(1)) dut1 (
        .clk(clk), .reset(reset), .load(ld1), .bin_in(bin1), .dp_in(dp1),
        .busy(busy1), .overflow(ovf1), .sel(sel1), .dig(dig1)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state: displayed value/dp/overflow and the pending conversion.
    int m_busy[2], m_left[2], m_pend[2], m_pdp[2], m_povf[2];
    int m_disp[2], m_dp[2], m_ovf[2];

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    function automatic int p10(int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] exp_dig(int v, int dp, int ovf, int i);
        logic [6:0] s;
        logic       b;
        if (ovf != 0)                  s = 7'b0111111;
        else if (i > 0 && v < p10(i))  s = 7'b1111111;
        else                           s = seg_tab[(v / p10(i)) % 10];
        b = (((dp >> i) & 1) == 0);
        return {b, s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [3:0] es [2];
        logic [7:0] ed [2];
        int         ld [2], bv [2], dv [2];
        int         idx;
        idx = (cyc / P) % D;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                es[k] = 4'hF;
                ed[k] = 8'hFF;
            end else begin
                es[k] = ~(4'b0001 << idx);
                ed[k] = exp_dig(m_disp[k], m_dp[k], m_ovf[k], idx);
            end
        end
        ld[0] = int'(ld0); bv[0] = int'(bin0); dv[0] = int'(dp0);
        ld[1] = int'(ld1); bv[1] = int'(bin1); dv[1] = int'(dp1);
        @(posedge clk);
        if (reset) begin
            cyc = 0;
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 0; m_left[k] = 0; m_disp[k] = 0; m_dp[k] = 0; m_ovf[k] = 0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (m_busy[k] != 0) begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        m_busy[k] = 0;
                        m_disp[k] = m_pend[k];
                        m_dp[k]   = m_pdp[k];
                        m_ovf[k]  = m_povf[k];
                    end
                end else if (ld[k] != 0) begin
                    m_busy[k] = 1;
                    m_left[k] = (k == 0) ? 8 : 16;
                    m_pend[k] = bv[k];
                    m_pdp[k]  = dv[k];
                    m_povf[k] = (bv[k] > p10(D) - 1) ? 1 : 0;
                end
            end
        end
        @(negedge clk);
        chk("sel0",  32'(sel0),  32'(es[0]));
        chk("dig0",  32'(dig0),  32'(ed[0]));
        chk("busy0", 32'(busy0), 32'(m_busy[0]));
        chk("ovf0",  32'(ovf0),  32'(m_ovf[0]));
        chk("sel1",  32'(sel1),  32'(es[1]));
        chk("dig1",  32'(dig1),  32'(ed[1]));
        chk("busy1", 32'(busy1), 32'(m_busy[1]));
        chk("ovf1",  32'(ovf1),  32'(m_ovf[1]));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the given digit is selected, then check its pattern.
    task automatic see(input int k, input logic [3:0] s, input logic [7:0] d, input string tag);
        int n = 0;
        while (((k == 0) ? sel0 : sel1) !== s && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_sel"}, 32'((k == 0) ? sel0 : sel1), 32'(s));
        chk(tag,           32'((k == 0) ? dig0 : dig1), 32'(d));
    endtask

    task automatic load0(input logic [7:0] v, input logic [3:0] dp);
        bin0 = v; dp0 = dp; ld0 = 1'b1;
        tick();
        ld0 = 1'b0;
    endtask

    task automatic load1(input logic [15:0] v, input logic [3:0] dp);
        bin1 = v; dp1 = dp; ld1 = 1'b1;
        tick();
        ld1 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        reset = 1'b1;
        ticks(3);
        chk("rst_sel", 32'(sel0), 32'h0000000F);
        chk("rst_dig", 32'(dig0), 32'h000000FF);
        reset = 1'b0;
        tick();
        chk("first_sel", 32'(sel0), 32'h0000000E);
        chk("first_dig", 32'(dig0), 32'h000000C0);
        ticks(16);

        load0(8'd173, 4'b0000);
        ticks(12);
        see(0, 4'b1110, 8'hB0, "d173_0");
        see(0, 4'b1101, 8'hF8, "d173_1");
        see(0, 4'b1011, 8'hF9, "d173_2");
        see(0, 4'b0111, 8'hFF, "d173_3");

        load0(8'd255, 4'b0000);
        ticks(2);
        load0(8'd42, 4'b0000);
        ticks(12);
        see(0, 4'b1110, 8'h92, "d255_0");
        see(0, 4'b1101, 8'h92, "d255_1");
        see(0, 4'b1011, 8'hA4, "d255_2");

        load0(8'd5, 4'b0010);
        ticks(12);
        see(0, 4'b1101, 8'h7F, "d5_1");
        see(0, 4'b1110, 8'h92, "d5_0");

        load1(16'd12345, 4'b0000);
        ticks(20);
        chk("ovf_set", 32'(ovf1), 32'd1);
        see(1, 4'b1110, 8'hBF, "ovf_0");
        see(1, 4'b1101, 8'hBF, "ovf_1");
        see(1, 4'b1011, 8'hBF, "ovf_2");
        see(1, 4'b0111, 8'hBF, "ovf_3");
        load1(16'd9999, 4'b0000);
        ticks(20);
        chk("ovf_clr", 32'(ovf1), 32'd0);
        see(1, 4'b1110, 8'h90, "d9999_0");
        see(1, 4'b0111, 8'h90, "d9999_3");

        // Load landing on the terminal-count edge of the prescaler.
        while (cyc % P != P - 1) tick();
        load0(8'd99, 4'b0101);
        ticks(20);

        for (int i = 0; i < 40; i++) begin
            bin0 = 8'($urandom);
            dp0  = 4'($urandom);
            ld0  = 1'($urandom_range(0, 1));
            bin1 = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 10000)) : 16'($urandom);
            dp1  = 4'($urandom);
            ld1  = 1'($urandom_range(0, 1));
            tick();
            ld0 = 1'b0;
            ld1 = 1'b0;
            ticks($urandom_range(0, 20));
        end
        ticks(20);

        load0(8'd7, 4'b0000);
        ticks(12);
        load0(8'd200, 4'b0000);
        ticks(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(busy0), 32'd0);
        see(0, 4'b1110, 8'hC0, "abort_d0");
        ticks(30);
        see(0, 4'b1110, 8'hC0, "abort_d0_late");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
